// File: rtl/minute_hour.sv
// Minutes/hours stage of a BCD clock: counts minute carries from the seconds
// stage, emits a day-rollover pulse, and lets the user set minutes and hours.
module minute_hour #(
  parameter int HOURS = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ci,
  input  logic       mode_btn,
  input  logic       inc_btn,
  output logic [3:0] ML,
  output logic [3:0] MH,
  output logic [3:0] HL,
  output logic [3:0] HH,
  output logic [1:0] set_state,
  output logic       co
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_MIN  = 2'b01,
    SET_HOUR = 2'b10
  } state_t;

  localparam logic [3:0] LAST_HH = 4'((HOURS - 1) / 10);
  localparam logic [3:0] LAST_HL = 4'((HOURS - 1) % 10);

  state_t state, state_next;
  logic   mode_d, inc_d;
  logic   mode_edge, inc_edge;
  logic   min_tick, hour_tick, roll;
  logic   min_last, hour_last;
  logic [3:0] ml_next, mh_next, hl_next, hh_next;

  assign mode_edge = mode_btn & ~mode_d;
  assign inc_edge  = inc_btn & ~inc_d;
  assign set_state = state;

  // Delay registers reset high so a button held through reset yields no edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_d <= 1'b1;
      inc_d  <= 1'b1;
    end else begin
      mode_d <= mode_btn;
      inc_d  <= inc_btn;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (mode_edge) begin
      case (state)
        RUN:      state_next = SET_MIN;
        SET_MIN:  state_next = SET_HOUR;
        SET_HOUR: state_next = RUN;
        default:  state_next = RUN;
      endcase
    end
  end

  assign min_last  = (MH >= 4'd5) && (ML >= 4'd9);
  assign hour_last = (HH == LAST_HH) && (HL == LAST_HL);

  // A mode edge takes priority over an inc edge arriving in the same cycle.
  always_comb begin
    min_tick  = 1'b0;
    hour_tick = 1'b0;
    roll      = 1'b0;
    case (state)
      RUN: begin
        if (ci) begin
          min_tick  = 1'b1;
          hour_tick = min_last;
          roll      = min_last && hour_last;
        end
      end
      SET_MIN:  min_tick  = inc_edge && !mode_edge;
      SET_HOUR: hour_tick = inc_edge && !mode_edge;
      default: begin
        min_tick  = 1'b0;
        hour_tick = 1'b0;
      end
    endcase
  end

  always_comb begin
    ml_next = ML + 4'd1;
    mh_next = MH;
    if (ML >= 4'd9) begin
      ml_next = 4'd0;
      mh_next = (MH >= 4'd5) ? 4'd0 : MH + 4'd1;
    end
  end

  always_comb begin
    hl_next = HL + 4'd1;
    hh_next = HH;
    if (hour_last) begin
      hl_next = 4'd0;
      hh_next = 4'd0;
    end else if (HL >= 4'd9) begin
      hl_next = 4'd0;
      hh_next = HH + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ML <= 4'd0;
      MH <= 4'd0;
      HL <= 4'd0;
      HH <= 4'd0;
      co <= 1'b0;
    end else begin
      if (min_tick) begin
        ML <= ml_next;
        MH <= mh_next;
      end
      if (hour_tick) begin
        HL <= hl_next;
        HH <= hh_next;
      end
      co <= roll;
    end
  end

endmodule
